vga_text_scanner: RTL and testbench

VGA_TEXT_SCANNER -- requirements
Module: vga_text_scanner

---
 rtl/vga_text_pkg.sv | 43 ++++
 rtl/vga_text_delay.sv | 27 ++
 rtl/vga_text_scanner.sv | 133 +++++++++++++
 tb/tb_vga_text_scanner.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and stage bundles for the 80x30 text-mode scanner.
// Cell geometry, attribute layout and the address helper live here.
package vga_text_pkg;

   localparam int COLS     = 80;
   localparam int ROWS     = 30;
   localparam int GLYPH_H  = 16;
   localparam int GLYPH_W  = 8;
   localparam int PIPE_LAT = 3;

   localparam logic [3:0] CURSOR_ROW_FIRST = 4'd14;

   localparam int ATTR_FG_LSB = 0;
   localparam int ATTR_FG_MSB = 3;
   localparam int ATTR_BG_LSB = 4;
   localparam int ATTR_BG_MSB = 6;
   localparam int ATTR_BLINK  = 7;

   typedef struct packed {
      logic [3:0] grow;
      logic [2:0] gcol;
      logic       hit;
   } s0_t;

   typedef struct packed {
      logic       chr7;
      logic [7:0] attr;
      logic [3:0] grow;
      logic [2:0] gcol;
      logic       hit;
   } s1_t;

   // row*80 + col without a multiplier
   function automatic logic [11:0] cell_addr(
      input logic [4:0] row,
      input logic [6:0] col
   );
      logic [11:0] r;
      r = {7'd0, row};
      return (r << 6) + (r << 4) + {5'd0, col};
   endfunction

endpackage

// File: rtl/vga_text_delay.sv
// Fixed-depth shift register used to align timing strobes with pixel data.
// Every stage reloads RST_VAL under synchronous reset.
module vga_text_delay #(
   parameter int             W       = 1,
   parameter int             D       = 3,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] q [D];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) q[i] <= RST_VAL;
      end else begin
         q[0] <= din;
         for (int i = 1; i < D; i++) q[i] <= q[i-1];
      end
   end

   assign dout = q[D-1];

endmodule

// File: rtl/vga_text_scanner.sv
// Text-mode pixel pipeline: cell address, char/attr fetch, glyph lookup, color.
// Three register stages from pix_x/pix_y/de_in to color and delayed syncs.
module vga_text_scanner
   import vga_text_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [11:0] tram_addr,
   input  logic [15:0] tram_rdata,
   output logic [6:0]  font_code,
   output logic [3:0]  font_row,
   output logic [2:0]  font_col,
   input  logic        font_pix_lo,
   input  logic        font_pix_hi,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_x,
   input  logic [4:0]  cursor_y,
   output logic [3:0]  color,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out
);

   logic [4:0] row;
   logic [6:0] col;
   logic [3:0] grow;
   logic [2:0] gcol;
   logic       hit0;
   s0_t        s0;
   s1_t        s1;

   assign row  = pix_y[8:4];
   assign col  = pix_x[9:3];
   assign grow = pix_y[3:0];
   assign gcol = pix_x[2:0];

   assign hit0 = cursor_en && (row == cursor_y) && (col == cursor_x)
                 && (grow >= CURSOR_ROW_FIRST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tram_addr <= '0;
         s0        <= '0;
      end else begin
         tram_addr <= cell_addr(row, col);
         s0        <= '{grow: grow, gcol: gcol, hit: hit0};
      end
   end

   assign font_code = tram_rdata[6:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
      end else begin
         s1 <= '{chr7: tram_rdata[7],
                 attr: tram_rdata[15:8],
                 grow: s0.grow,
                 gcol: s0.gcol,
                 hit:  s0.hit};
      end
   end

   assign font_row = s1.grow;
   assign font_col = s1.gcol;

   logic       vs_hist;
   logic [4:0] frame_cnt;
   logic       blink_phase;

   // History resets high so releasing reset with vsync idle never counts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_hist   <= 1'b1;
         frame_cnt <= '0;
      end else begin
         vs_hist <= vsync_in;
         if (vs_hist && !vsync_in) frame_cnt <= frame_cnt + 5'd1;
      end
   end

   assign blink_phase = frame_cnt[4];

   logic de_d2;

   vga_text_delay #(.W(1), .D(2), .RST_VAL(1'b0)) u_de_a (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (de_in),
      .dout  (de_d2)
   );

   vga_text_delay #(.W(1), .D(1), .RST_VAL(1'b0)) u_de_b (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (de_d2),
      .dout  (de_out)
   );

   vga_text_delay #(.W(2), .D(3), .RST_VAL(2'b11)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({hsync_in, vsync_in}),
      .dout  ({hsync_out, vsync_out})
   );

   logic       pix;
   logic       cur_vis;
   logic       lit;
   logic [3:0] color_d;

   always_comb begin
      pix     = s1.chr7 ? font_pix_hi : font_pix_lo;
      cur_vis = s1.hit & blink_phase;
      lit     = (pix ^ cur_vis) & ~(s1.attr[ATTR_BLINK] & ~blink_phase);
      color_d = 4'h0;
      if (de_d2) begin
         color_d = lit ? s1.attr[ATTR_FG_MSB:ATTR_FG_LSB]
                       : {1'b0, s1.attr[ATTR_BG_MSB:ATTR_BG_LSB]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) color <= 4'h0;
      else        color <= color_d;
   end

endmodule

// File: tb/tb_vga_text_scanner.sv
// Directed bench for vga_text_scanner with behavioural text RAM and font ROMs.
// Each task streams pixels and compares color three clocks later.
module tb_vga_text_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic        de_in, hsync_in, vsync_in;
   logic [11:0] tram_addr;
   logic [15:0] tram_rdata;
   logic [6:0]  font_code;
   logic [3:0]  font_row;
   logic [2:0]  font_col;
   logic        font_pix_lo, font_pix_hi;
   logic        cursor_en;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic [3:0]  color;
   logic        de_out, hsync_out, vsync_out;

   logic [15:0] tram [4096];
   logic [6:0]  fc_q = '0;
   int errors = 0;
   int checks = 0;
   int tb_frames = 0;

   vga_text_scanner dut (
      .clk(clk), .rst_n(rst_n),
      .pix_x(pix_x), .pix_y(pix_y),
      .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .tram_addr(tram_addr), .tram_rdata(tram_rdata),
      .font_code(font_code), .font_row(font_row), .font_col(font_col),
      .font_pix_lo(font_pix_lo), .font_pix_hi(font_pix_hi),
      .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
      .color(color), .de_out(de_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   always #5 clk = ~clk;

   function automatic bit glyph_lo(int code, int r, int c);
      return ((r * 3 + c + code) % 4) < 2;
   endfunction

   function automatic bit glyph_hi(int code, int r, int c);
      return ((r + c) % 2) == 1;
   endfunction

   assign tram_rdata = tram[tram_addr];
   always @(posedge clk) fc_q <= font_code;
   assign font_pix_lo = glyph_lo(int'(fc_q), int'(font_row), int'(font_col));
   assign font_pix_hi = glyph_hi(int'(fc_q), int'(font_row), int'(font_col));

   function automatic logic [3:0] ref_color(int x, int y, bit de);
      int row, col, r, c;
      logic [15:0] w;
      bit phase, p, cv, lit;
      row = (y / 16) % 32;
      col = x / 8;
      r = y % 16;
      c = x % 8;
      w = tram[(row * 80 + col) % 4096];
      phase = (tb_frames % 32) >= 16;
      p = w[7] ? glyph_hi(int'(w[6:0]), r, c) : glyph_lo(int'(w[6:0]), r, c);
      cv = cursor_en && (col == int'(cursor_x)) && (row == int'(cursor_y))
           && (r >= 14) && phase;
      lit = (p ^ cv) && !(w[15] && !phase);
      if (!de) return 4'h0;
      return lit ? w[11:8] : {1'b0, w[14:12]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int x, int y, bit de);
      pix_x = x[9:0];
      pix_y = y[9:0];
      de_in = de;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
   endtask

   task automatic vsync_pulse();
      drive(0, 0, 1'b0);
      vsync_in = 1'b0;
      tick();
      vsync_in = 1'b1;
      tick();
      tb_frames++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 1'b0);
      tick();
      rst_n = 1'b1;
      tb_frames = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(639, 479, 1'b1);
      hsync_in = 1'b0;
      tick();
      tick();
      checks++;
      if (tram_addr !== 12'd0) begin
         errors++; $display("FAIL reset_addr: got %0d want 0", tram_addr);
      end
      checks++;
      if (color !== 4'h0 || de_out !== 1'b0) begin
         errors++; $display("FAIL reset_color_de: got %h/%b want 0/0", color, de_out);
      end
      checks++;
      if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
         errors++; $display("FAIL reset_sync: got %b%b want 11", hsync_out, vsync_out);
      end
      checks++;
      if (dut.frame_cnt !== 5'd0) begin
         errors++; $display("FAIL reset_frame: got %0d want 0", dut.frame_cnt);
      end
      rst_n = 1'b1;
      drive(0, 0, 1'b0);
      tick();
   endtask

   task automatic test_addr();
      int xs [4] = '{639, 0, 639, 8};
      int ys [4] = '{479, 16, 511, 0};
      logic [11:0] ex [4] = '{12'd2399, 12'd80, 12'd2559, 12'd1};
      for (int i = 0; i < 4; i++) begin
         drive(xs[i], ys[i], 1'b1);
         tick();
         checks++;
         if (tram_addr !== ex[i]) begin
            errors++;
            $display("FAIL addr_%0d: got %0d want %0d", i, tram_addr, ex[i]);
         end
      end
      drive(0, 0, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_glyph_a();
      logic [3:0] q[$];
      logic [3:0] e;
      tram[0] = 16'h0741;
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 8; x++) begin
            drive(x, y, 1'b1);
            q.push_back(ref_color(x, y, 1'b1));
            tick();
            if (q.size() == 3) begin
               e = q.pop_front();
               checks++;
               if (color !== e || de_out !== 1'b1) begin
                  errors++;
                  $display("FAIL glyph_a: got %h/%b want %h/1", color, de_out, e);
               end
            end
         end
      end
      drive(0, 0, 1'b0);
      repeat (2) begin
         tick();
         e = q.pop_front();
         checks++;
         if (color !== e) begin
            errors++; $display("FAIL glyph_a_tail: got %h want %h", color, e);
         end
      end
   endtask

   task automatic test_hi_rom();
      logic [3:0] q[$];
      logic [3:0] e;
      tram[1] = 16'h1FDB;
      for (int y = 0; y < 16; y++) begin
         for (int x = 8; x < 16; x++) begin
            drive(x, y, 1'b1);
            q.push_back((((y + x - 8) & 1) == 1) ? 4'hF : 4'h1);
            tick();
            if (q.size() == 3) begin
               e = q.pop_front();
               checks++;
               if (color !== e) begin
                  errors++; $display("FAIL hi_rom: got %h want %h", color, e);
               end
            end
         end
      end
      drive(0, 0, 1'b0);
      repeat (2) begin
         tick();
         e = q.pop_front();
         checks++;
         if (color !== e) begin
            errors++; $display("FAIL hi_rom_tail: got %h want %h", color, e);
         end
      end
   endtask

   task automatic test_de_mask();
      logic [3:0] q[$];
      logic [3:0] e;
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 8; x++) begin
            drive(x, y, (x % 2) == 0);
            q.push_back(ref_color(x, y, (x % 2) == 0));
            tick();
            if (q.size() == 3) begin
               e = q.pop_front();
               checks++;
               if (color !== e) begin
                  errors++; $display("FAIL de_mask: got %h want %h", color, e);
               end
            end
         end
      end
      drive(0, 0, 1'b0);
      repeat (2) begin
         tick();
         e = q.pop_front();
         checks++;
         if (color !== e) begin
            errors++; $display("FAIL de_mask_tail: got %h want %h", color, e);
         end
      end
   endtask

   task automatic test_sync_align();
      drive(0, 0, 1'b1);
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      tick();
      tb_frames++;
      drive(0, 0, 1'b0);
      tick();
      checks++;
      if (de_out !== 1'b0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
         errors++;
         $display("FAIL sync_early: got %b%b%b want 011", de_out, hsync_out, vsync_out);
      end
      tick();
      checks++;
      if (de_out !== 1'b1 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || color !== 4'h7) begin
         errors++;
         $display("FAIL sync_align: got %b%b%b c=%h want 100 c=7",
                  de_out, hsync_out, vsync_out, color);
      end
      tick();
      checks++;
      if (de_out !== 1'b0 || hsync_out !== 1'b1 || color !== 4'h0) begin
         errors++;
         $display("FAIL sync_after: got %b%b c=%h want 01 c=0", de_out, hsync_out, color);
      end
   endtask

   task automatic test_blink();
      logic [3:0] q[$];
      logic [3:0] e;
      do_reset();
      tram[2] = 16'h8741;
      for (int k = 0; k < 40; k++) begin
         if (k == 31 || k == 32) begin
            checks++;
            if (dut.frame_cnt !== 5'(k % 32)) begin
               errors++;
               $display("FAIL frame_wrap: got %0d want %0d", dut.frame_cnt, k % 32);
            end
         end
         for (int x = 16; x < 24; x++) begin
            drive(x, 0, 1'b1);
            q.push_back(ref_color(x, 0, 1'b1));
            tick();
            if (q.size() == 3) begin
               e = q.pop_front();
               checks++;
               if (color !== e) begin
                  errors++;
                  $display("FAIL blink_f%0d: got %h want %h", k, color, e);
               end
            end
         end
         drive(0, 0, 1'b0);
         repeat (2) begin
            tick();
            e = q.pop_front();
            checks++;
            if (color !== e) begin
               errors++; $display("FAIL blink_tail: got %h want %h", color, e);
            end
         end
         vsync_pulse();
      end
   endtask

   task automatic test_cursor();
      logic [3:0] q[$];
      logic [3:0] e;
      do_reset();
      tram[245] = 16'h0741;
      tram[246] = 16'h0741;
      cursor_en = 1'b1;
      cursor_x = 7'd5;
      cursor_y = 5'd3;
      for (int pass = 0; pass < 2; pass++) begin
         for (int y = 60; y < 64; y++) begin
            for (int x = 40; x < 56; x++) begin
               drive(x, y, 1'b1);
               q.push_back(ref_color(x, y, 1'b1));
               tick();
               if (q.size() == 3) begin
                  e = q.pop_front();
                  checks++;
                  if (color !== e) begin
                     errors++;
                     $display("FAIL cursor_p%0d: got %h want %h", pass, color, e);
                  end
               end
            end
         end
         drive(0, 0, 1'b0);
         repeat (2) begin
            tick();
            e = q.pop_front();
            checks++;
            if (color !== e) begin
               errors++; $display("FAIL cursor_tail: got %h want %h", color, e);
            end
         end
         if (pass == 0) repeat (16) vsync_pulse();
      end
      drive(40, 62, 1'b1);
      repeat (3) tick();
      checks++;
      if (color !== 4'h7) begin
         errors++; $display("FAIL cursor_hand: got %h want 7", color);
      end
      cursor_en = 1'b0;
      drive(0, 0, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      for (int x = 0; x < 5; x++) begin
         drive(x, 0, 1'b1);
         tick();
      end
      repeat (3) vsync_pulse();
      drive(0, 0, 1'b1);
      hsync_in = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if (color !== 4'h0 || de_out !== 1'b0 || tram_addr !== 12'd0) begin
         errors++;
         $display("FAIL mid_reset: got c=%h de=%b a=%0d want 0/0/0", color, de_out, tram_addr);
      end
      checks++;
      if (hsync_out !== 1'b1 || vsync_out !== 1'b1 || dut.frame_cnt !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset_sync: got %b%b f=%0d want 11 f=0",
                  hsync_out, vsync_out, dut.frame_cnt);
      end
      rst_n = 1'b1;
      tb_frames = 0;
      drive(0, 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (color !== 4'h0 || de_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_%0d: got %h/%b want 0/0", i, color, de_out);
         end
      end
      tick();
      checks++;
      if (color !== 4'h7 || de_out !== 1'b1) begin
         errors++; $display("FAIL mid_first: got %h/%b want 7/1", color, de_out);
      end
      checks++;
      if (dut.frame_cnt !== 5'd0) begin
         errors++; $display("FAIL mid_frame: got %0d want 0", dut.frame_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) tram[i] = 16'h0000;
      rst_n = 1'b0;
      cursor_en = 1'b0;
      cursor_x = '0;
      cursor_y = '0;
      drive(0, 0, 1'b0);
      test_reset();
      test_addr();
      test_glyph_a();
      test_hi_rom();
      test_de_mask();
      test_sync_align();
      test_blink();
      test_cursor();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
